mips_regfile: RTL and testbench
===============================

// Module: mips_regfile
// PURPOSE
// - MIPS general-purpose register file: 32 x 32-bit registers, one write port, two read ports.
// - Sits in the multi-cycle MIPS core.
// - Read port 0 supplies rt/store data; read port 1 supplies rs/base.
// - The write port is driven by the writeback stage and by the core's SP/RA initialisation.
// PARAMETERS
// - DATA_W    32  register width in bits
// - NUM_REGS  32  number of architectural registers
// - ADDR_W    5   register index width; must equal $clog2(NUM_REGS)
// - BYPASS    0   1 = a read of the register being written this cycle returns wr_data
// PORTS
// - clk       in   1       single clock; all state updates on posedge
// - reset     in   1       asynchronous, active-high; clears all registers
// - wr_num    in   ADDR_W  write register index
// - wr_data   in   DATA_W  write data
// - wr_en     in   1       write enable, sampled at posedge clk
// - rd0_num   in   ADDR_W  read port 0 index
// - rd0_data  out  DATA_W  read port 0 data (combinational)
// - rd1_num   in   ADDR_W  read port 1 index
// - rd1_data  out  DATA_W  read port 1 data (combinational)
// - Interface: one clock; reset is asynchronous and active-high.
// BEHAVIOUR
// - Storage: regs[0..NUM_REGS-1] of DATA_W bits each.
// - Reset:
//   - reset=1 immediately (no clock needed) forces every regs[i]=0.
//   - While reset=1, rd0_data=rd1_data=0 and writes are ignored.
// - Write:
//   - At posedge clk with reset=0 and wr_en=1, regs[wr_num] <= wr_data.
//   - When wr_num==0 the write is discarded.
//   - With wr_en=0, no state change.
// - R0: reads of index 0 always return 0, including in bypass mode.
// - Read:
//   - rdN_data = regs[rdN_num], purely combinational, zero cycles of latency.
//   - The new value is visible right after the writing clock edge.
// - Same-index read/write in the same cycle:
//   - BYPASS=0: old value until the edge, new value after it.
//   - BYPASS=1: rdN_data = wr_data whenever wr_en=1 and rdN_num==wr_num!=0.
// - Both read ports may address the same register; each returns an identical value.
// - Reset asserted mid-write: reset wins and the write is lost.
// - Reset deasserted: all registers are 0 and normal writes resume on the next posedge.
// - No X propagation: indices are full-range, so no out-of-range case exists when NUM_REGS=2**ADDR_W.
// STRUCTURE
// - Shared package mips_pkg:
//   - REG_W=32 and REG_ADDR_W=5.
//   - typedef logic [31:0] word_t; typedef logic [4:0] reg_idx_t.
//   - Named indices REG_ZERO=0, REG_SP=29, REG_RA=31.
// - Sub-module: none.
//   - Write logic is a single always_ff (async reset).
//   - Each read port is a continuous assign with the R0 mask and optional bypass mux.
// TESTING
// - Reset: pulse reset mid-cycle -> all 32 registers read 0 on both ports without a clock edge.
// - Write/read: write 0x80120000 to R29, then 0x00000000 to R31 -> rd1_num=29 gives 0x80120000; rd0_num=31 gives 0.
// - R0: wr_en=1, wr_num=0, wr_data=0xDEADBEEF -> rd0_num=0 still returns 0.
// - Enable: wr_en=0, wr_num=5, data 0x1234 -> R5 unchanged (0).
// - Hazard: R7=0x11, then same cycle write R7=0x22 with rd0_num=7:
//   - BYPASS=0 -> 0x11 before the edge, 0x22 after.
//   - BYPASS=1 -> 0x22 immediately.
// - Reset during writes: write all regs with index*3, assert reset -> all 0.
//   - Writes after deassert land normally; random sweep checked against a model.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: register-file geometry,
// word/index types and the architecturally named registers.
package mips_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;
    localparam reg_idx_t REG_SP   = 5'd29;
    localparam reg_idx_t REG_RA   = 5'd31;

endpackage

// File: rtl/mips_regfile_if.sv
// Register-file access bundle: one write port and two
// combinational read ports, as seen from the core.
interface mips_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);

    logic [ADDR_W-1:0] wr_num;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic [ADDR_W-1:0] rd0_num;
    logic [DATA_W-1:0] rd0_data;
    logic [ADDR_W-1:0] rd1_num;
    logic [DATA_W-1:0] rd1_data;

    modport master (
        output wr_num,
        output wr_data,
        output wr_en,
        output rd0_num,
        output rd1_num,
        input  rd0_data,
        input  rd1_data
    );

    modport slave (
        input  wr_num,
        input  wr_data,
        input  wr_en,
        input  rd0_num,
        input  rd1_num,
        output rd0_data,
        output rd1_data
    );

endinterface

// File: rtl/mips_regfile.sv
// MIPS general-purpose register file: NUM_REGS x DATA_W,
// one write port, two combinational read ports, R0 hardwired to 0.
module mips_regfile
    import mips_pkg::*;
#(
    parameter int DATA_W   = REG_W,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int BYPASS   = 0
) (
    input  logic           clk,
    input  logic           reset,
    mips_regfile_if.slave  rf
);

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] idx_t;

    localparam idx_t IDX_ZERO = ADDR_W'(REG_ZERO);

    data_t regs_q [NUM_REGS];
    data_t regs_d [NUM_REGS];

    logic  wr_ok;
    logic  wr_in_range;
    logic  rd0_in_range;
    logic  rd1_in_range;
    logic  rd0_hit;
    logic  rd1_hit;
    data_t rd0_raw;
    data_t rd1_raw;

    // Indices past NUM_REGS only exist when NUM_REGS < 2**ADDR_W.
    assign wr_in_range  = (32'(rf.wr_num)  < NUM_REGS);
    assign rd0_in_range = (32'(rf.rd0_num) < NUM_REGS);
    assign rd1_in_range = (32'(rf.rd1_num) < NUM_REGS);

    // Writes to R0 are dropped so it never holds anything but 0.
    assign wr_ok = rf.wr_en && (rf.wr_num != IDX_ZERO) && wr_in_range;

    // Next-state: copy current contents, overlay the single write.
    always_comb begin
        regs_d = regs_q;
        if (wr_ok) begin
            regs_d[rf.wr_num] = rf.wr_data;
        end
    end

    // Register storage, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rd0_raw = rd0_in_range ? regs_q[rf.rd0_num] : '0;
    assign rd1_raw = rd1_in_range ? regs_q[rf.rd1_num] : '0;

    // Forwarding only matters in bypass builds; R0 is excluded by wr_ok.
    assign rd0_hit = (BYPASS != 0) && wr_ok &&
                     (rf.rd0_num == rf.wr_num);
    assign rd1_hit = (BYPASS != 0) && wr_ok &&
                     (rf.rd1_num == rf.wr_num);

    // Reset and R0 force zero ahead of any forwarded value.
    assign rf.rd0_data = (reset || rf.rd0_num == IDX_ZERO) ? '0 :
                         rd0_hit ? rf.wr_data : rd0_raw;

    assign rf.rd1_data = (reset || rf.rd1_num == IDX_ZERO) ? '0 :
                         rd1_hit ? rf.wr_data : rd1_raw;

endmodule

// File: tb/tb_mips_regfile.sv
// Self-checking bench for mips_regfile: drives a BYPASS=0 and a
// BYPASS=1 instance in lockstep against an array reference model.
module tb_mips_regfile;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic     we  = 1'b0;
    reg_idx_t wn  = '0;
    word_t    wd  = '0;
    reg_idx_t r0n = '0;
    reg_idx_t r1n = '0;

    word_t model [32];

    int n_checks = 0;
    int n_fail   = 0;

    mips_regfile_if #(.DATA_W(32), .ADDR_W(5)) if0 ();
    mips_regfile_if #(.DATA_W(32), .ADDR_W(5)) if1 ();

    assign if0.wr_en   = we;
    assign if0.wr_num  = wn;
    assign if0.wr_data = wd;
    assign if0.rd0_num = r0n;
    assign if0.rd1_num = r1n;
    assign if1.wr_en   = we;
    assign if1.wr_num  = wn;
    assign if1.wr_data = wd;
    assign if1.rd0_num = r0n;
    assign if1.rd1_num = r1n;

    mips_regfile #(.BYPASS(0)) dut0 (
        .clk   (clk),
        .reset (rst),
        .rf    (if0.slave)
    );

    mips_regfile #(.BYPASS(1)) dut1 (
        .clk   (clk),
        .reset (rst),
        .rf    (if1.slave)
    );

    always #5 clk = ~clk;

    function automatic word_t exp_rd(reg_idx_t idx, bit byp);
        if (rst) return '0;
        if (idx == REG_ZERO) return '0;
        if (byp && we && idx == wn) return wd;
        return model[idx];
    endfunction

    task automatic chk(string tag, word_t obs, word_t expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic check_reads(string tag);
        chk({tag, ":b0.rd0"}, if0.rd0_data, exp_rd(r0n, 1'b0));
        chk({tag, ":b0.rd1"}, if0.rd1_data, exp_rd(r1n, 1'b0));
        chk({tag, ":b1.rd0"}, if1.rd0_data, exp_rd(r0n, 1'b1));
        chk({tag, ":b1.rd1"}, if1.rd1_data, exp_rd(r1n, 1'b1));
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst && we && wn != REG_ZERO) model[wn] = wd;
        #1;
    endtask

    task automatic sweep_all(string tag);
        for (int i = 0; i < 32; i++) begin
            r0n = reg_idx_t'(i);
            r1n = reg_idx_t'(31 - i);
            #1;
            check_reads(tag);
        end
    endtask

    task automatic write(reg_idx_t n, word_t d);
        @(negedge clk);
        we = 1'b1;
        wn = n;
        wd = d;
        tick();
        @(negedge clk);
        we = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 'x;

        // async reset before any clock edge
        #2;
        rst = 1'b1;
        clear_model();
        #1;
        check_reads("rst_async");
        sweep_all("rst_all");

        // writes ignored while reset held
        @(negedge clk);
        we = 1'b1; wn = 5'd3; wd = 32'hCAFE_0003;
        r0n = 5'd3; r1n = 5'd3;
        #1;
        check_reads("rst_wr_pre");
        tick();
        check_reads("rst_wr_post");
        @(negedge clk);
        we = 1'b0;
        rst = 1'b0;
        #1;
        check_reads("rst_release");

        // SP / RA
        write(REG_SP, 32'h8012_0000);
        write(REG_RA, 32'h0000_0000);
        r1n = REG_SP; r0n = REG_RA;
        #1;
        check_reads("sp_ra");
        chk("sp_const", if0.rd1_data, 32'h8012_0000);
        chk("ra_const", if0.rd0_data, 32'h0000_0000);

        // R0 stays zero, also through bypass
        @(negedge clk);
        we = 1'b1; wn = REG_ZERO; wd = 32'hDEAD_BEEF;
        r0n = REG_ZERO; r1n = REG_ZERO;
        #1;
        check_reads("r0_pre");
        tick();
        check_reads("r0_post");
        chk("r0_b1_const", if1.rd0_data, 32'h0);
        @(negedge clk);
        we = 1'b0;

        // write enable low
        @(negedge clk);
        we = 1'b0; wn = 5'd5; wd = 32'h0000_1234;
        r0n = 5'd5; r1n = 5'd5;
        tick();
        check_reads("en_low");
        chk("en_low_const", if0.rd0_data, 32'h0);

        // same-cycle read/write hazard
        write(5'd7, 32'h11);
        @(negedge clk);
        we = 1'b1; wn = 5'd7; wd = 32'h22;
        r0n = 5'd7; r1n = 5'd7;
        #1;
        check_reads("haz_pre");
        chk("haz_b0_pre", if0.rd0_data, 32'h11);
        chk("haz_b1_pre", if1.rd0_data, 32'h22);
        tick();
        check_reads("haz_post");
        chk("haz_b0_post", if0.rd0_data, 32'h22);
        @(negedge clk);
        we = 1'b0;

        // fill with index*3, then reset mid-write
        for (int i = 0; i < 32; i++) begin
            write(reg_idx_t'(i), word_t'(i * 3));
        end
        sweep_all("fill");
        @(negedge clk);
        we = 1'b1; wn = 5'd9; wd = 32'h9999_9999;
        #2;
        rst = 1'b1;
        clear_model();
        #1;
        check_reads("rst_mid");
        sweep_all("rst_mid_all");
        tick();
        @(negedge clk);
        we = 1'b0;
        rst = 1'b0;
        sweep_all("after_rst");

        write(5'd9, 32'h0BAD_F00D);
        r0n = 5'd9; r1n = 5'd9;
        #1;
        check_reads("after_rst_wr");

        // random sweep
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            we  = ($urandom_range(0, 3) != 0);
            wn  = reg_idx_t'($urandom_range(0, 31));
            wd  = word_t'($urandom);
            r0n = reg_idx_t'($urandom_range(0, 31));
            r1n = ($urandom_range(0, 3) == 0) ? r0n :
                  reg_idx_t'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) r0n = wn;
            #1;
            check_reads("rnd_pre");
            tick();
            check_reads("rnd_post");
        end
        @(negedge clk);
        we = 1'b0;
        sweep_all("final");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
